fft16_sequencer: RTL

Control sequencer that feeds the radix-2 butterfly unit to compute an in-place 16-point decimation-in-time FFT from a single sample RAM.
- Loads 16 input samples into RAM at bit-reversed addresses.
- Runs the four butterfly stages: issues RAM read pairs and twiddle indices to the butterfly, then issues the matching RAM write-back pairs when results emerge.
- Is the producer side of the butterfly's operand/twiddle interface and owns all RAM addressing.
- Contains no datapath arithmetic.

---
 rtl/fft16_if.sv | 31 +++
 rtl/fft16_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/fft16_if.sv
// Sample-load, operand-read, twiddle and write-back bundle between the FFT
// sequencer (master) and the RAM/butterfly environment (slave).
interface fft16_if;
    logic       start;
    logic       s_valid;
    logic       s_ready;
    logic       ld_wr_en;
    logic [3:0] ld_addr;
    logic       rd_en;
    logic [3:0] rd_addr_a;
    logic [3:0] rd_addr_b;
    logic [3:0] twiddle_num;
    logic       wr_en;
    logic [3:0] wr_addr_a;
    logic [3:0] wr_addr_b;
    logic [1:0] stage;
    logic       busy;
    logic       done;

    modport master (
        input  start, s_valid,
        output s_ready, ld_wr_en, ld_addr, rd_en, rd_addr_a, rd_addr_b, twiddle_num,
               wr_en, wr_addr_a, wr_addr_b, stage, busy, done
    );

    modport slave (
        output start, s_valid,
        input  s_ready, ld_wr_en, ld_addr, rd_en, rd_addr_a, rd_addr_b, twiddle_num,
               wr_en, wr_addr_a, wr_addr_b, stage, busy, done
    );
endinterface

// File: rtl/fft16_sequencer.sv
// In-place 16-point radix-2 DIT FFT control: bit-reversed load, four butterfly
// stages of read issue, and delayed write-back addressing. No arithmetic here.
module fft16_sequencer #(
    parameter int RD_LAT   = 1,
    parameter int BF_LAT   = 3,
    parameter int PIPE_LAT = RD_LAT + BF_LAT
) (
    input  logic    clk,
    input  logic    rst,
    fft16_if.master bus
);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

    state_t                   state, state_nxt;
    logic [3:0]               ld_cnt;
    logic [2:0]               bf_cnt;
    logic [1:0]               stage;
    logic [DW-1:0]            drain_cnt;
    logic                     ld_fire, drain_last, issuing;
    logic [3:0]               bf_ext, j, g, addr_a, addr_b, tw_idx;
    logic [PIPE_LAT-1:0]      vld_pipe;
    logic [PIPE_LAT-1:0][3:0] pa_pipe, pb_pipe;
    logic [RD_LAT-1:0][3:0]   tw_pipe;

    assign issuing    = (state == ISSUE);
    assign ld_fire    = bus.s_valid && (state == LOAD);
    assign drain_last = (drain_cnt == DW'(PIPE_LAT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    if (ld_fire && ld_cnt == 4'd15) state_nxt = ISSUE;
            ISSUE:   if (bf_cnt == 3'd7) state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = (stage == 2'd3) ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Pair p of stage s: group g = p>>s, offset j = p mod 2^s, span 2^(s+1).
    always_comb begin
        bf_ext = {1'b0, bf_cnt};
        j      = bf_ext & ((4'd1 << stage) - 4'd1);
        g      = bf_ext >> stage;
        addr_a = ((g << stage) << 1) | j;
        addr_b = addr_a + (4'd1 << stage);
        tw_idx = j << (2'd3 - stage);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt    <= '0;
            bf_cnt    <= '0;
            stage     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (ld_fire) ld_cnt <= ld_cnt + 4'd1;
                    bf_cnt <= '0;
                    stage  <= '0;
                end
                ISSUE: begin
                    bf_cnt    <= bf_cnt + 3'd1;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    drain_cnt <= drain_last ? '0 : drain_cnt + DW'(1);
                    if (drain_last && stage != 2'd3) stage <= stage + 2'd1;
                end
                DONE:    stage <= '0;
                default: ;
            endcase
        end
    end

    // Write-back addresses ride alongside the read pair until the butterfly result emerges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            pa_pipe  <= '0;
            pb_pipe  <= '0;
            tw_pipe  <= '0;
        end else begin
            vld_pipe[0] <= issuing;
            pa_pipe[0]  <= issuing ? addr_a : 4'd0;
            pb_pipe[0]  <= issuing ? addr_b : 4'd0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pa_pipe[i]  <= pa_pipe[i-1];
                pb_pipe[i]  <= pb_pipe[i-1];
            end
            tw_pipe[0] <= issuing ? tw_idx : 4'd0;
            for (int i = 1; i < RD_LAT; i++) tw_pipe[i] <= tw_pipe[i-1];
        end
    end

    assign bus.s_ready     = (state == LOAD);
    assign bus.ld_wr_en    = ld_fire;
    assign bus.ld_addr     = {ld_cnt[0], ld_cnt[1], ld_cnt[2], ld_cnt[3]};
    assign bus.rd_en       = issuing;
    assign bus.rd_addr_a   = issuing ? addr_a : 4'd0;
    assign bus.rd_addr_b   = issuing ? addr_b : 4'd0;
    assign bus.twiddle_num = tw_pipe[RD_LAT-1];
    assign bus.wr_en       = vld_pipe[PIPE_LAT-1];
    assign bus.wr_addr_a   = pa_pipe[PIPE_LAT-1];
    assign bus.wr_addr_b   = pb_pipe[PIPE_LAT-1];
    assign bus.stage       = stage;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
endmodule
